// File: rtl/barrel_shift_arbiter.sv
// Two-requester round-robin arbiter feeding one shared 4-bit rotate-right unit
// and a single output register, with saturating per-requester delivery counters.
module barrel_shift_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [3:0]       req0_data,
  input  logic [1:0]       req0_amt,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_data,
  input  logic [1:0]       req1_amt,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [3:0]       out_data,
  output logic             out_id,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             rr_ptr
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state;
  logic       out_free;
  logic       consume;
  logic       grant_valid;
  logic       grant_id;
  logic       accept;
  logic [3:0] sel_data;
  logic [1:0] sel_amt;
  logic [3:0] rot_data;

  function automatic logic [3:0] rotate_right(input logic [3:0] d, input logic [1:0] amt);
    logic [3:0] r;
    case (amt)
      2'd0:    r = d;
      2'd1:    r = {d[0],   d[3:1]};
      2'd2:    r = {d[1:0], d[3:2]};
      default: r = {d[2:0], d[3]};
    endcase
    return r;
  endfunction

  assign out_valid = (state == FULL);
  assign consume   = out_valid & out_ready;
  assign out_free  = ~out_valid | out_ready;

  // Grant looks only at who is asking; rr_ptr breaks ties.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = rr_ptr;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Ready is gated by rst so both readies read low for the whole reset window.
  assign req0_ready = ~rst & out_free & grant_valid & ~grant_id;
  assign req1_ready = ~rst & out_free & grant_valid &  grant_id;
  assign accept     = ~rst & out_free & grant_valid;

  assign sel_data = grant_id ? req1_data : req0_data;
  assign sel_amt  = grant_id ? req1_amt  : req0_amt;
  assign rot_data = rotate_right(sel_data, sel_amt);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= 4'd0;
      out_id   <= 1'b0;
      rr_ptr   <= 1'b0;
      cnt0     <= '0;
      cnt1     <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) state <= FULL;
        end
        FULL: begin
          if (consume && !accept) state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase

      if (accept) begin
        out_data <= rot_data;
        out_id   <= grant_id;
        rr_ptr   <= ~grant_id;
      end

      if (consume && !out_id && cnt0 != '1) cnt0 <= cnt0 + CNT_W'(1);
      if (consume &&  out_id && cnt1 != '1) cnt1 <= cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Randomised and directed bench for barrel_shift_arbiter; two instances (CNT_W=8 and 2)
// share stimulus and are compared against a transaction-level reference model.
module tb_barrel_shift_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1, out_ready;
  logic [3:0] d0, d1;
  logic [1:0] a0, a1;

  logic       r0, r1, ov, oid, rr;
  logic [3:0] od;
  logic [7:0] c0, c1;
  logic       r0_b, r1_b, ov_b, oid_b, rr_b;
  logic [3:0] od_b;
  logic [1:0] c0_b, c1_b;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit         m_v, m_id, m_rr;
  logic [3:0] m_d;
  int         m_c0, m_c1;

  always #5 clk = ~clk;

  barrel_shift_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_data(d0), .req0_amt(a0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_amt(a1), .req1_ready(r1),
    .out_valid(ov), .out_data(od), .out_id(oid), .out_ready(out_ready),
    .cnt0(c0), .cnt1(c1), .rr_ptr(rr)
  );

  barrel_shift_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_data(d0), .req0_amt(a0), .req0_ready(r0_b),
    .req1_valid(v1), .req1_data(d1), .req1_amt(a1), .req1_ready(r1_b),
    .out_valid(ov_b), .out_data(od_b), .out_id(oid_b), .out_ready(out_ready),
    .cnt0(c0_b), .cnt1(c1_b), .rr_ptr(rr_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] rot(input logic [3:0] d, input logic [1:0] a);
    logic [7:0] t;
    t = {d, d} >> a;
    return t[3:0];
  endfunction

  function automatic int sat(input int c, input int max);
    return (c > max) ? max : c;
  endfunction

  task automatic model_reset();
    m_v = 0; m_id = 0; m_rr = 0; m_d = 4'd0; m_c0 = 0; m_c1 = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(ov), 32'(m_v));
    check("out_valid_sat", 32'(ov_b), 32'(m_v));
    if (m_v) begin
      check("out_data", 32'(od), 32'(m_d));
      check("out_id", 32'(oid), 32'(m_id));
      check("out_data_sat", 32'(od_b), 32'(m_d));
    end
    check("rr_ptr", 32'(rr), 32'(m_rr));
    check("cnt0", 32'(c0), sat(m_c0, 255));
    check("cnt1", 32'(c1), sat(m_c1, 255));
    check("cnt0_sat", 32'(c0_b), sat(m_c0, 3));
    check("cnt1_sat", 32'(c1_b), sat(m_c1, 3));
  endtask

  // Inputs must already be set; called just after a falling edge, ends at the next one.
  task automatic step();
    bit free, gv, g;
    #1;
    free = !m_v || out_ready;
    gv   = v0 || v1;
    g    = (v0 && v1) ? m_rr : v1;
    check("req0_ready", 32'(r0), 32'(free && gv && !g));
    check("req1_ready", 32'(r1), 32'(free && gv && g));
    check("req0_ready_sat", 32'(r0_b), 32'(free && gv && !g));
    check("req1_ready_sat", 32'(r1_b), 32'(free && gv && g));
    if (m_v && out_ready) begin
      if (m_id) m_c1++; else m_c0++;
    end
    if (free && gv) begin
      m_d  = g ? rot(d1, a1) : rot(d0, a0);
      m_id = g;
      m_v  = 1;
      m_rr = !g;
    end else if (m_v && out_ready) begin
      m_v = 0;
    end
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_out_valid", 32'(ov), 0);
    check("rst_out_data", 32'(od), 0);
    check("rst_out_id", 32'(oid), 0);
    check("rst_ready0", 32'(r0), 0);
    check("rst_ready1", 32'(r1), 0);
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp031 [4];
    logic [3:0] held;
    rst = 1'b1; out_ready = 1'b0;
    v0 = 0; v1 = 0; d0 = 0; d1 = 0; a0 = 0; a1 = 0;
    @(negedge clk);
    apply_reset();

    // single requester, all four rotate amounts
    exp031 = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};
    out_ready = 1; v0 = 1; d0 = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      a0 = 2'(k);
      step();
      check("r031_data", 32'(od), 32'(exp031[k]));
    end
    v0 = 0;
    step();
    check("r031_cnt0", 32'(c0), 4);

    // contention from reset: grants alternate starting with requester 0
    apply_reset();
    v0 = 1; v1 = 1; out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      d0 = 4'($urandom); d1 = 4'($urandom); a0 = 2'($urandom); a1 = 2'($urandom);
      step();
      check("r032_id", 32'(oid), 32'(k % 2));
      check("r032_rr", 32'(rr), 32'((k + 1) % 2));
    end

    // backpressure: hold for five cycles then release
    out_ready = 0;
    held = od;
    for (int k = 0; k < 5; k++) begin
      step();
      check("r033_hold", 32'(od), 32'(held));
    end
    out_ready = 1;
    step();

    // reset between edges with a held result
    out_ready = 0; v1 = 0;
    step();
    #2;
    rst = 1'b1;
    #1;
    check("r034_valid", 32'(ov), 0);
    check("r034_cnt0", 32'(c0), 0);
    check("r034_cnt1", 32'(c1), 0);
    check("r034_rr", 32'(rr), 0);
    @(negedge clk);
    apply_reset();

    // saturation on the narrow counter instance
    v0 = 0; v1 = 1; out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      d1 = 4'($urandom); a1 = 2'($urandom);
      step();
    end
    v1 = 0;
    step();
    check("r035_cnt1_sat", 32'(c1_b), 3);
    check("r035_cnt0_sat", 32'(c0_b), 0);
    check("r035_cnt1_wide", 32'(c1), 5);

    // random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      d0 = 4'($urandom); d1 = 4'($urandom);
      a0 = 2'($urandom); a1 = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) apply_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
